// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - shared geometry defaults and loader FSM encoding
package led_matrix_pkg;

  localparam int DEFAULT_ROWS  = 8;
  localparam int DEFAULT_COLS  = 8;
  localparam int DEFAULT_BW    = 8;
  localparam int PIX_PER_FRAME = DEFAULT_ROWS * DEFAULT_COLS;

  typedef enum logic [1:0] {
    ST_LOAD      = 2'd0,
    ST_DISCARD   = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } loader_state_e;

endpackage

// File: rtl/led_frame_bank.sv
// rtl/led_frame_bank.sv - one row-addressed RGB brightness bank
module led_frame_bank
  import led_matrix_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,
  parameter int COLS = DEFAULT_COLS,
  parameter int BW   = DEFAULT_BW,
  localparam int ROW_W = $clog2(ROWS),
  localparam int COL_W = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [ROW_W-1:0]     wr_row_i,
  input  logic [COL_W-1:0]     wr_col_i,
  input  logic [3*BW-1:0]      wr_data_i,
  input  logic [ROW_W-1:0]     rd_row_i,
  output logic [COLS*BW-1:0]   rd_r_o,
  output logic [COLS*BW-1:0]   rd_g_o,
  output logic [COLS*BW-1:0]   rd_b_o
);

  logic [COLS*BW-1:0] r_q [ROWS];
  logic [COLS*BW-1:0] g_q [ROWS];
  logic [COLS*BW-1:0] b_q [ROWS];

  // Reset clears every cell so the matrix comes up dark.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++) begin
        r_q[i] <= '0;
        g_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else if (we_i) begin
      r_q[wr_row_i][int'(wr_col_i)*BW +: BW] <= wr_data_i[3*BW-1 -: BW];
      g_q[wr_row_i][int'(wr_col_i)*BW +: BW] <= wr_data_i[2*BW-1 -: BW];
      b_q[wr_row_i][int'(wr_col_i)*BW +: BW] <= wr_data_i[BW-1:0];
    end
  end

  assign rd_r_o = r_q[rd_row_i];
  assign rd_g_o = g_q[rd_row_i];
  assign rd_b_o = b_q[rd_row_i];

endmodule

// File: rtl/led_frame_loader.sv
// rtl/led_frame_loader.sv - pixel stream to double-buffered LED frame store with tear-free swap
module led_frame_loader
  import led_matrix_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,
  parameter int COLS = DEFAULT_COLS,
  parameter int BW   = DEFAULT_BW,
  localparam int ROW_W = $clog2(ROWS),
  localparam int COL_W = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [3*BW-1:0]      s_data,
  input  logic                 s_last,
  input  logic [ROW_W-1:0]     scan_row,
  input  logic                 scan_frame_end,
  output logic [COLS*BW-1:0]   rd_r,
  output logic [COLS*BW-1:0]   rd_g,
  output logic [COLS*BW-1:0]   rd_b,
  output logic                 swap_pending,
  output logic                 frame_err
);

  loader_state_e      state_q;
  logic               s_ready_q;
  logic               swap_pending_q;
  logic               frame_err_q;
  logic               bank_sel_q;
  logic [ROW_W-1:0]   wr_row_q, wr_row_d;
  logic [COL_W-1:0]   wr_col_q, wr_col_d;
  logic [COLS*BW-1:0] rd_r_q, rd_g_q, rd_b_q;

  logic accept;
  logic last_px;
  logic wr_en;
  logic [COLS*BW-1:0] b0_r, b0_g, b0_b, b1_r, b1_g, b1_b;

  assign accept  = s_valid && s_ready_q;
  assign last_px = (wr_row_q == ROW_W'(ROWS-1)) && (wr_col_q == COL_W'(COLS-1));
  assign wr_en   = accept && (state_q == ST_LOAD);

  always_comb begin
    wr_col_d = wr_col_q + 1'b1;
    wr_row_d = wr_row_q;
    if (wr_col_q == COL_W'(COLS-1)) begin
      wr_col_d = '0;
      wr_row_d = wr_row_q + 1'b1;
    end
  end

  // s_ready tracks the state being entered, so nothing is taken once WAIT_SWAP is committed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_LOAD;
      s_ready_q      <= 1'b0;
      swap_pending_q <= 1'b0;
      frame_err_q    <= 1'b0;
      bank_sel_q     <= 1'b0;
      wr_row_q       <= '0;
      wr_col_q       <= '0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          s_ready_q      <= 1'b1;
          swap_pending_q <= 1'b0;
          if (accept) begin
            if (last_px) begin
              wr_row_q <= '0;
              wr_col_q <= '0;
              if (s_last) begin
                state_q        <= ST_WAIT_SWAP;
                s_ready_q      <= 1'b0;
                swap_pending_q <= 1'b1;
              end else begin
                state_q     <= ST_DISCARD;
                frame_err_q <= 1'b1;
              end
            end else if (s_last) begin
              frame_err_q <= 1'b1;
              wr_row_q    <= '0;
              wr_col_q    <= '0;
            end else begin
              wr_row_q <= wr_row_d;
              wr_col_q <= wr_col_d;
            end
          end
        end
        ST_DISCARD: begin
          s_ready_q <= 1'b1;
          if (accept && s_last) begin
            state_q <= ST_LOAD;
          end
        end
        ST_WAIT_SWAP: begin
          s_ready_q      <= 1'b0;
          swap_pending_q <= 1'b1;
          if (scan_frame_end) begin
            state_q        <= ST_LOAD;
            bank_sel_q     <= ~bank_sel_q;
            s_ready_q      <= 1'b1;
            swap_pending_q <= 1'b0;
            wr_row_q       <= '0;
            wr_col_q       <= '0;
          end
        end
        default: begin
          state_q   <= ST_LOAD;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // bank_sel_q names the front bank; writes only ever go to the other one.
  led_frame_bank #(.ROWS(ROWS), .COLS(COLS), .BW(BW)) u_bank0 (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wr_en && bank_sel_q),
    .wr_row_i  (wr_row_q),
    .wr_col_i  (wr_col_q),
    .wr_data_i (s_data),
    .rd_row_i  (scan_row),
    .rd_r_o    (b0_r),
    .rd_g_o    (b0_g),
    .rd_b_o    (b0_b)
  );

  led_frame_bank #(.ROWS(ROWS), .COLS(COLS), .BW(BW)) u_bank1 (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wr_en && !bank_sel_q),
    .wr_row_i  (wr_row_q),
    .wr_col_i  (wr_col_q),
    .wr_data_i (s_data),
    .rd_row_i  (scan_row),
    .rd_r_o    (b1_r),
    .rd_g_o    (b1_g),
    .rd_b_o    (b1_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_r_q <= '0;
      rd_g_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_r_q <= bank_sel_q ? b1_r : b0_r;
      rd_g_q <= bank_sel_q ? b1_g : b0_g;
      rd_b_q <= bank_sel_q ? b1_b : b0_b;
    end
  end

  assign s_ready      = s_ready_q;
  assign swap_pending = swap_pending_q;
  assign frame_err    = frame_err_q;
  assign rd_r         = rd_r_q;
  assign rd_g         = rd_g_q;
  assign rd_b         = rd_b_q;

endmodule

// File: tb/tb_led_frame_loader.sv
// tb/tb_led_frame_loader.sv - directed scoreboard bench for led_frame_loader
module tb_led_frame_loader;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int BW   = 8;

  typedef struct {
    logic [COLS*BW-1:0] r;
    logic [COLS*BW-1:0] g;
    logic [COLS*BW-1:0] b;
  } row_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [3*BW-1:0]    s_data = '0;
  logic               s_last = 1'b0;
  logic [2:0]         scan_row = '0;
  logic               scan_frame_end = 1'b0;
  logic [COLS*BW-1:0] rd_r, rd_g, rd_b;
  logic               swap_pending;
  logic               frame_err;

  int   errors = 0;
  int   checks = 0;
  int   err_seen = 0;
  row_t sb_q[$];
  row_t front_m [ROWS];

  led_frame_loader #(.ROWS(ROWS), .COLS(COLS), .BW(BW)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .scan_row       (scan_row),
    .scan_frame_end (scan_frame_end),
    .rd_r           (rd_r),
    .rd_g           (rd_g),
    .rd_b           (rd_b),
    .swap_pending   (swap_pending),
    .frame_err      (frame_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_seen++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3*BW-1:0] pix(input int seed, input int idx);
    logic [7:0] r8, g8, b8;
    r8 = 8'((idx % COLS) * 4 + seed);
    g8 = 8'((idx / COLS) * 8 + seed);
    b8 = 8'(255 - seed);
    return {r8, g8, b8};
  endfunction

  function automatic row_t row_img(input int seed, input int r);
    row_t t;
    logic [3*BW-1:0] p;
    for (int c = 0; c < COLS; c++) begin
      p = pix(seed, r*COLS + c);
      t.r[c*BW +: BW] = p[23:16];
      t.g[c*BW +: BW] = p[15:8];
      t.b[c*BW +: BW] = p[7:0];
    end
    return t;
  endfunction

  task automatic push_frame_exp(input int seed);
    for (int r = 0; r < ROWS; r++) sb_q.push_back(row_img(seed, r));
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic push_px(input logic [3*BW-1:0] d, input logic last, input logic sfe);
    int budget;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    scan_frame_end = sfe;
    budget = 0;
    while (s_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("px_accept_timeout", 64'(budget < 50), 64'(1));
    @(negedge clk);
    scan_frame_end = 1'b0;
  endtask

  task automatic send(input int seed, input int count, input int last_idx, input logic sfe_on_last);
    for (int i = 0; i < count; i++)
      push_px(pix(seed, i), i == last_idx, sfe_on_last && (i == count-1));
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic pulse_sfe(input logic exp_swap);
    chk("swap_pending_before_sfe", 64'(swap_pending), 64'(exp_swap));
    scan_frame_end = 1'b1;
    @(negedge clk);
    scan_frame_end = 1'b0;
    if (exp_swap) begin
      chk("sb_has_frame", 64'(sb_q.size() >= ROWS), 64'(1));
      for (int r = 0; r < ROWS; r++) if (sb_q.size() > 0) front_m[r] = sb_q.pop_front();
      chk("s_ready_after_swap", 64'(s_ready), 64'(1));
      chk("swap_pending_after_swap", 64'(swap_pending), 64'(0));
    end
  endtask

  task automatic check_rows(input string tag);
    for (int r = 0; r < ROWS; r++) begin
      scan_row = 3'(r);
      @(negedge clk);
      chk({tag, "_r"}, rd_r, front_m[r].r);
      chk({tag, "_g"}, rd_g, front_m[r].g);
      chk({tag, "_b"}, rd_b, front_m[r].b);
    end
  endtask

  task automatic clear_front();
    for (int r = 0; r < ROWS; r++) front_m[r] = '{r: '0, g: '0, b: '0};
  endtask

  initial begin
    int e0;
    clear_front();
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_swap_pending", 64'(swap_pending), 64'(0));
    chk("rst_frame_err", 64'(frame_err), 64'(0));
    chk("rst_rd_r", rd_r, 64'(0));
    rst = 1'b1;
    #1 chk("s_ready_before_first_edge", 64'(s_ready), 64'(0));
    @(negedge clk);
    chk("s_ready_after_release", 64'(s_ready), 64'(1));

    // Full frame, no frame end for 1000 cycles: held back, front still dark
    send(1, ROWS*COLS, ROWS*COLS-1, 1'b0);
    push_frame_exp(1);
    chk("wait_s_ready", 64'(s_ready), 64'(0));
    repeat (1000) @(negedge clk);
    chk("hold_s_ready", 64'(s_ready), 64'(0));
    chk("hold_swap_pending", 64'(swap_pending), 64'(1));
    check_rows("hold_dark");
    pulse_sfe(1'b1);
    check_rows("swap_seed1");

    // Gradient frame: row 3 reads r=c*4, g=24, b=FF
    send(0, ROWS*COLS, ROWS*COLS-1, 1'b0);
    push_frame_exp(0);
    pulse_sfe(1'b1);
    scan_row = 3'd3;
    @(negedge clk);
    chk("row3_r", rd_r, 64'h1c18_1410_0c08_0400);
    chk("row3_g", rd_g, 64'h1818_1818_1818_1818);
    chk("row3_b", rd_b, 64'hffff_ffff_ffff_ffff);
    check_rows("swap_seed0");

    // Early s_last: one error pulse, no swap, recovery
    e0 = err_seen;
    send(2, 11, 10, 1'b0);
    @(negedge clk);
    chk("early_last_err_count", 64'(err_seen - e0), 64'(1));
    chk("early_last_s_ready", 64'(s_ready), 64'(1));
    pulse_sfe(1'b0);
    repeat (2) @(negedge clk);
    check_rows("early_last_noswap");
    send(3, ROWS*COLS, ROWS*COLS-1, 1'b0);
    push_frame_exp(3);
    pulse_sfe(1'b1);
    check_rows("recover_seed3");

    // Missing s_last: error, discard 5 px, next frame displays
    e0 = err_seen;
    send(4, ROWS*COLS, -1, 1'b0);
    send(9, 5, 4, 1'b0);
    @(negedge clk);
    chk("missing_last_err_count", 64'(err_seen - e0), 64'(1));
    chk("discard_no_pending", 64'(swap_pending), 64'(0));
    chk("discard_s_ready", 64'(s_ready), 64'(1));
    send(5, ROWS*COLS, ROWS*COLS-1, 1'b0);
    push_frame_exp(5);
    pulse_sfe(1'b1);
    check_rows("after_discard_seed5");

    // Final accept coincident with frame end: swap waits for next pulse
    send(6, ROWS*COLS, ROWS*COLS-1, 1'b1);
    push_frame_exp(6);
    repeat (2) @(negedge clk);
    chk("coincident_pending", 64'(swap_pending), 64'(1));
    check_rows("coincident_noswap");
    pulse_sfe(1'b1);
    check_rows("coincident_next_swap");

    // Reset mid-frame after a good swap
    send(7, 30, -1, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_s_ready", 64'(s_ready), 64'(0));
    chk("midrst_rd_r", rd_r, 64'(0));
    chk("midrst_rd_g", rd_g, 64'(0));
    chk("midrst_rd_b", rd_b, 64'(0));
    @(negedge clk);
    chk("midrst_s_ready_held", 64'(s_ready), 64'(0));
    chk("midrst_swap_pending", 64'(swap_pending), 64'(0));
    rst = 1'b1;
    clear_front();
    @(negedge clk);
    check_rows("post_rst_dark");
    send(8, ROWS*COLS, ROWS*COLS-1, 1'b0);
    push_frame_exp(8);
    pulse_sfe(1'b1);
    check_rows("post_rst_seed8");
    chk("sb_empty_at_end", 64'(sb_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
